// File: rtl/period_meter.sv
// period_meter
// Measures the period and high time of a slow, possibly asynchronous square
// wave, expressed in clock_in cycles.
//
// Ports:
//   clock_in      system clock
//   reset         synchronous, active-high reset
//   enable        measurement enable (level); low forces the block idle
//   signal_in     waveform to measure, asynchronous to clock_in
//   period_out    last measured period (cycles between two detected rises)
//   high_out      last measured high time (cycles with level=1 in that period)
//   measure_valid one-cycle pulse when period_out/high_out update
//   timeout       sticky level; no rise arrived within TIMEOUT cycles
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 32'd100000000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             signal_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             measure_valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] L_TIMEOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] L_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_lvl;
  logic             r_prev;
  logic             w_rise;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_hcount;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_hcount_nxt;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] w_high_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;

  // Two-flop synchronizer followed by a previous-level flop for edge detect.
  // The 2-3 cycle latency is identical for every rise, so it cancels out of
  // the measured period.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_lvl   <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= signal_in;
      r_lvl   <= r_sync1;
      r_prev  <= r_lvl;
    end
  end

  assign w_rise = r_lvl & ~r_prev;

  // Next-state and next-value logic; enable low overrides everything else,
  // and a rise wins over the timeout when both land on the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_hcount_nxt  = r_hcount;
    w_period_nxt  = period_out;
    w_high_nxt    = high_out;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = timeout;
    if (!enable) begin
      w_state_nxt  = S_IDLE;
      w_count_nxt  = L_ZERO;
      w_hcount_nxt = L_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_ARM;
          w_count_nxt  = L_ZERO;
          w_hcount_nxt = L_ZERO;
        end
        S_ARM: begin
          if (w_rise) begin
            // First rise only opens a measurement window, nothing is captured.
            w_state_nxt  = S_MEASURE;
            w_count_nxt  = L_ONE;
            w_hcount_nxt = L_ONE;
          end else begin
            w_state_nxt  = S_ARM;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_period_nxt  = r_count;
            w_high_nxt    = r_hcount;
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
            w_count_nxt   = L_ONE;
            w_hcount_nxt  = L_ONE;
          end else if (r_count < L_TIMEOUT) begin
            // hcount never exceeds count, and count stops at TIMEOUT: no wrap.
            w_count_nxt  = r_count + L_ONE;
            w_hcount_nxt = r_hcount + {{(WIDTH-1){1'b0}}, r_lvl};
          end else begin
            w_timeout_nxt = 1'b1;
            w_count_nxt   = L_ZERO;
            w_hcount_nxt  = L_ZERO;
            w_state_nxt   = S_ARM;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_count_nxt  = L_ZERO;
          w_hcount_nxt = L_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= L_ZERO;
      r_hcount      <= L_ZERO;
      period_out    <= L_ZERO;
      high_out      <= L_ZERO;
      measure_valid <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_hcount      <= w_hcount_nxt;
      period_out    <= w_period_nxt;
      high_out      <= w_high_nxt;
      measure_valid <= w_valid_nxt;
      timeout       <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter with TIMEOUT=50. A behavioural model
// derives expected outputs from the list of detected rise cycles: period is
// the distance between accepted rises, high time is the sum of sampled levels
// in that window.
module tb_period_meter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 50;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             signal_in;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             measure_valid;
  logic             timeout;

  period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock_in     (clk),
    .reset        (rst),
    .enable       (enable),
    .signal_in    (signal_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .measure_valid(measure_valid),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc = 0;
  bit          lvl_hist [0:8191];
  bit          m_d1 = 1'b0, m_d2 = 1'b0, m_d3 = 1'b0; // input latency line
  bit          ready = 1'b0;     // an enabled cycle has already passed
  int          anchor = -1;      // cycle of last accepted rise, -1 if none
  logic [31:0] exp_period = 32'd0;
  logic [31:0] exp_high = 32'd0;
  logic        exp_valid = 1'b0;
  logic        exp_timeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Advance one clock: update the model from the inputs about to be sampled,
  // then compare all outputs shortly after the edge.
  task automatic tick();
    bit lvl, rise;
    int hsum;
    lvl  = m_d2;
    rise = m_d2 & ~m_d3;
    lvl_hist[cyc] = lvl;
    if (rst) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_d3 = 1'b0;
    end else begin
      m_d3 = m_d2; m_d2 = m_d1; m_d1 = signal_in;
    end
    exp_valid = 1'b0;
    if (rst) begin
      exp_period = 32'd0; exp_high = 32'd0; exp_timeout = 1'b0;
      ready = 1'b0; anchor = -1;
    end else if (!enable) begin
      ready = 1'b0; anchor = -1;
    end else if (!ready) begin
      ready = 1'b1;
    end else if (rise) begin
      if (anchor >= 0) begin
        hsum = 0;
        for (int m = anchor; m < cyc; m++) hsum += int'(lvl_hist[m]);
        exp_period  = 32'(cyc - anchor);
        exp_high    = 32'(hsum);
        exp_valid   = 1'b1;
        exp_timeout = 1'b0;
      end
      anchor = cyc;
    end else if (anchor >= 0 && cyc - anchor == TIMEOUT) begin
      exp_timeout = 1'b1;
      anchor = -1;
    end
    @(posedge clk);
    #1;
    check("period_out", period_out, exp_period);
    check("high_out", high_out, exp_high);
    check("measure_valid", 32'(measure_valid), 32'(exp_valid));
    check("timeout", 32'(timeout), 32'(exp_timeout));
    cyc++;
  endtask

  // Drive a square wave for n cycles with optional enable drop or reset pulse.
  // first_ev: index of first pulse at/after the event; first_to: first index
  // with timeout high; npulses: pulses seen in the phase.
  task automatic run_wave(input int per, input int hi, input int n,
                          input int drop_at, input int drop_len, input int rst_at,
                          output int first_ev, output int first_to, output int npulses);
    int ev;
    ev = (drop_at >= 0) ? drop_at : rst_at;
    first_ev = -1; first_to = -1; npulses = 0;
    for (int i = 0; i < n; i++) begin
      signal_in = ((i % per) < hi);
      enable    = !(drop_at >= 0 && i >= drop_at && i < drop_at + drop_len);
      rst       = (i == rst_at);
      tick();
      if (measure_valid === 1'b1) begin
        npulses++;
        if (ev >= 0 && i >= ev && first_ev < 0) first_ev = i;
      end
      if (timeout === 1'b1 && first_to < 0) first_to = i;
      if (i == rst_at) begin
        check("rst_mid_period", period_out, 32'd0);
        check("rst_mid_high", high_out, 32'd0);
        check("rst_mid_valid", 32'(measure_valid), 32'd0);
        check("rst_mid_timeout", 32'(timeout), 32'd0);
      end
    end
    rst = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    int fe, ft, np, per, hi, n, da;
    rst = 1'b1; enable = 1'b1; signal_in = 1'b0;
    repeat (3) tick();
    check("reset_period", period_out, 32'd0);
    check("reset_high", high_out, 32'd0);
    check("reset_valid", 32'(measure_valid), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // square wave 10/6: 8 rises, first only arms
    run_wave(10, 6, 80, -1, 0, -1, fe, ft, np);
    check("sq_pulses", 32'(np), 32'd7);
    check("sq_period", period_out, 32'd10);
    check("sq_high", high_out, 32'd6);
    check("sq_timeout", 32'(timeout), 32'd0);

    // minimum period: toggle every cycle
    run_wave(2, 1, 24, -1, 0, -1, fe, ft, np);
    check("min_pulses", 32'(np), 32'd11);
    check("min_period", period_out, 32'd2);
    check("min_high", high_out, 32'd1);

    // hold low: rise from previous phase lands at index 0, timeout at 50
    run_wave(100, 0, 60, -1, 0, -1, fe, ft, np);
    check("to_first_cycle", 32'(ft), 32'd50);
    check("to_pulses", 32'(np), 32'd1);
    check("to_period_held", period_out, 32'd2);
    check("to_high_held", high_out, 32'd1);
    check("to_flag", 32'(timeout), 32'd1);

    // recovery with period 20: first rise re-arms, next two measure
    run_wave(20, 7, 60, -1, 0, -1, fe, ft, np);
    check("rec_pulses", 32'(np), 32'd2);
    check("rec_period", period_out, 32'd20);
    check("rec_high", high_out, 32'd7);
    check("rec_timeout", 32'(timeout), 32'd0);

    // boundary: spacing exactly TIMEOUT is a valid measurement
    run_wave(100, 0, 60, -1, 0, -1, fe, ft, np);
    run_wave(50, 1, 150, -1, 0, -1, fe, ft, np);
    check("b50_pulses", 32'(np), 32'd2);
    check("b50_period", period_out, 32'd50);
    check("b50_high", high_out, 32'd1);
    check("b50_timeout", 32'(timeout), 32'd0);

    // spacing 51: only the carried-over 50-gap rise measures, then timeouts
    run_wave(51, 1, 153, -1, 0, -1, fe, ft, np);
    check("b51_pulses", 32'(np), 32'd1);
    check("b51_first_to", 32'(ft), 32'd52);
    check("b51_timeout", 32'(timeout), 32'd1);
    check("b51_period_held", period_out, 32'd50);

    // enable drop for 5 cycles mid-period; first pulse needs two fresh rises
    run_wave(12, 5, 96, 40, 5, -1, fe, ft, np);
    check("drop_first_pulse", 32'(fe), 32'd62);
    check("drop_period", period_out, 32'd12);
    check("drop_high", high_out, 32'd5);
    check("drop_timeout", 32'(timeout), 32'd0);

    // one-cycle reset mid-measurement
    run_wave(16, 9, 128, -1, 0, 40, fe, ft, np);
    check("rst_first_pulse", 32'(fe), 32'd66);
    check("rst_period", period_out, 32'd16);
    check("rst_high", high_out, 32'd9);

    // randomized waves, sometimes with an enable drop
    for (int k = 0; k < 6; k++) begin
      per = int'($urandom_range(40, 2));
      hi  = int'($urandom_range(per - 1, 1));
      n   = per * int'($urandom_range(6, 3));
      da  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
      run_wave(per, hi, n, da, int'($urandom_range(8, 1)), -1, fe, ft, np);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
